// File: rtl/eth_rx_filter_pkg.sv
// Shared types and constants for the Ethernet receive filter and its packet buffer.
package eth_rx_filter_pkg;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  empty;
    logic        sop;
    logic        eop;
  } rx_word_t;

  localparam logic [47:0] ETH_BCAST = 48'hFFFF_FFFF_FFFF;

  // Byte offsets within the frame; byte0 sits in bits [63:56] of each word.
  localparam int DST_MAC_OFS = 0;
  localparam int ETYPE_OFS   = 12;
  localparam int ETYPE_WORD  = ETYPE_OFS / 8;
  localparam int DST_LSB     = 64 - 8 * (DST_MAC_OFS % 8) - 48;
  localparam int ETYPE_LSB   = 64 - 8 * (ETYPE_OFS % 8) - 16;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HDR1,
    WR_BODY,
    WR_DISCARD
  } wr_state_e;

  function automatic logic [47:0] get_dst(input logic [63:0] w);
    return w[DST_LSB +: 48];
  endfunction

  function automatic logic [15:0] get_etype(input logic [63:0] w);
    return w[ETYPE_LSB +: 16];
  endfunction

endpackage

// File: rtl/pkt_fifo_rb.sv
// Packet buffer with start mark, commit and rollback, a registered RAM read and a
// 2-entry show-ahead output stage. Space is reclaimed only when a word leaves the output.
module pkt_fifo_rb
  import eth_rx_filter_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  rx_word_t wr_word,
  input  logic     start,
  input  logic     abort,
  input  logic     drop,
  input  logic     commit,
  output logic     full,
  output rx_word_t out_word,
  output logic     out_valid,
  input  logic     out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_USED = PW'(DEPTH - 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] start_ptr_q, start_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wbase;

  rx_word_t mem [DEPTH];
  rx_word_t ram_q;
  logic     ram_vld_q, ram_vld_d;
  rx_word_t ent0_q, ent0_d;
  rx_word_t ent1_q, ent1_d;
  logic [1:0] out_cnt_q, out_cnt_d;
  logic [1:0] cnt_after_pop;
  logic [2:0] inflight;
  logic       pop;
  logic       rd_en;

  // An abort restarts the open frame at its start mark in the same cycle it writes.
  always_comb begin
    wbase        = abort ? start_ptr_q : wr_ptr_q;
    full         = (wbase - rd_ptr_q) == FULL_USED;
    wr_ptr_d     = drop ? start_ptr_q : wbase + PW'(wr_en);
    start_ptr_d  = start ? wbase : start_ptr_q;
    commit_ptr_d = commit ? wbase + PW'(wr_en) : commit_ptr_q;
  end

  assign out_valid = (out_cnt_q != 2'd0);
  assign out_word  = ent0_q;

  // Fetch only when the word can land in the output stage two edges later.
  always_comb begin
    pop           = out_valid & out_ready;
    inflight      = 3'(out_cnt_q) + 3'(ram_vld_q) - 3'(pop);
    rd_en         = (fetch_ptr_q != commit_ptr_q) && (inflight <= 3'd1);
    fetch_ptr_d   = fetch_ptr_q + PW'(rd_en);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    ram_vld_d     = rd_en;
    cnt_after_pop = out_cnt_q - 2'(pop);
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    if (pop) begin
      ent0_d = ent1_q;
    end
    if (ram_vld_q) begin
      if (cnt_after_pop == 2'd0) begin
        ent0_d = ram_q;
      end else begin
        ent1_d = ram_q;
      end
    end
    out_cnt_d = cnt_after_pop + 2'(ram_vld_q);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wbase[AW-1:0]] <= wr_word;
    end
    if (rd_en) begin
      ram_q <= mem[fetch_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      commit_ptr_q <= '0;
      fetch_ptr_q  <= '0;
      rd_ptr_q     <= '0;
      ram_vld_q    <= 1'b0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      out_cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_vld_q    <= ram_vld_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

endmodule

// File: rtl/eth_rx_filter.sv
// Store-and-forward receive filter: validates each frame while buffering it and
// forwards only whole good frames; rejected frames are rolled back out of the buffer.
module eth_rx_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int          DEPTH     = 512,
  parameter logic [15:0] ETHERTYPE = 16'h8915,
  parameter int          MIN_BYTES = 60,
  parameter int          MAX_BYTES = 1514
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [47:0] localMac,
  input  logic [63:0] in_data,
  input  logic [2:0]  in_empty,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_error,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] rx_data,
  output logic [2:0]  rx_empty,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic        rx_error,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [15:0] goodCnt,
  output logic [15:0] dropCnt
);

  localparam logic [11:0] MIN_B = 12'(MIN_BYTES);
  localparam logic [11:0] MAX_B = 12'(MAX_BYTES);

  wr_state_e   state_q, state_d;
  logic [8:0]  word_cnt_q, word_cnt_d;
  logic        bad_q, bad_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        accept;
  logic        sop_go;
  logic [8:0]  cnt_next;
  logic [11:0] byte_len;
  logic        bad_next;
  logic        dst_bad;
  logic        good_inc;
  logic [1:0]  drop_inc;
  logic [16:0] good_sum;
  logic [16:0] drop_sum;

  logic        f_wr_en;
  logic        f_start;
  logic        f_abort;
  logic        f_drop;
  logic        f_commit;
  logic        f_full;
  rx_word_t    f_wr_word;
  rx_word_t    f_out_word;

  assign f_wr_word = '{data: in_data, empty: in_empty, sop: in_sop, eop: in_eop};

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    bad_d      = bad_q;
    f_wr_en    = 1'b0;
    f_start    = 1'b0;
    f_abort    = 1'b0;
    f_drop     = 1'b0;
    f_commit   = 1'b0;
    good_inc   = 1'b0;
    drop_inc   = 2'd0;
    sop_go     = 1'b0;
    accept     = in_valid & in_ready_q;
    cnt_next   = word_cnt_q + 9'd1;
    byte_len   = {cnt_next, 3'b000} - {9'd0, in_empty};
    bad_next   = bad_q | ((state_q == WR_HDR1) && (get_etype(in_data) != ETHERTYPE));
    dst_bad    = (get_dst(in_data) != localMac) && (get_dst(in_data) != ETH_BCAST);

    case (state_q)
      WR_IDLE: begin
        if (accept && in_sop) begin
          sop_go = 1'b1;
        end
      end
      WR_HDR1, WR_BODY: begin
        if (accept) begin
          if (in_sop) begin
            f_abort  = 1'b1;
            drop_inc = 2'd1;
            sop_go   = 1'b1;
          end else if (in_eop) begin
            state_d = WR_IDLE;
            if (!bad_next && !in_error && !f_full && (byte_len >= MIN_B) && (byte_len <= MAX_B)) begin
              f_wr_en  = 1'b1;
              f_commit = 1'b1;
              good_inc = 1'b1;
            end else begin
              f_drop   = 1'b1;
              drop_inc = 2'd1;
            end
          end else if (f_full || ({cnt_next, 3'b000} > MAX_B)) begin
            state_d = WR_DISCARD;
          end else begin
            f_wr_en    = 1'b1;
            word_cnt_d = cnt_next;
            bad_d      = bad_next;
            state_d    = WR_BODY;
          end
        end
      end
      WR_DISCARD: begin
        if (accept && in_eop) begin
          f_drop   = 1'b1;
          drop_inc = 2'd1;
          state_d  = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase

    // A new sop, whether from IDLE or restarting over an open frame.
    if (sop_go) begin
      if (in_eop) begin
        f_drop   = f_abort;
        drop_inc = drop_inc + 2'd1;
        state_d  = WR_IDLE;
      end else begin
        f_start    = 1'b1;
        word_cnt_d = 9'd1;
        bad_d      = dst_bad;
        if (f_full) begin
          state_d = WR_DISCARD;
        end else begin
          f_wr_en = 1'b1;
          state_d = WR_HDR1;
        end
      end
    end

    in_ready_d = 1'b1;
    good_sum   = {1'b0, good_cnt_q} + 17'(good_inc);
    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
    good_cnt_d = good_sum[16] ? 16'hFFFF : good_sum[15:0];
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= WR_IDLE;
      word_cnt_q <= 9'd0;
      bad_q      <= 1'b0;
      in_ready_q <= 1'b0;
      good_cnt_q <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      bad_q      <= bad_d;
      in_ready_q <= in_ready_d;
      good_cnt_q <= good_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  pkt_fifo_rb #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clock),
    .rst      (reset),
    .wr_en    (f_wr_en),
    .wr_word  (f_wr_word),
    .start    (f_start),
    .abort    (f_abort),
    .drop     (f_drop),
    .commit   (f_commit),
    .full     (f_full),
    .out_word (f_out_word),
    .out_valid(rx_valid),
    .out_ready(rx_ready)
  );

  assign rx_data  = f_out_word.data;
  assign rx_empty = f_out_word.empty;
  assign rx_sop   = f_out_word.sop;
  assign rx_eop   = f_out_word.eop;
  assign rx_error = 1'b0;
  assign in_ready = in_ready_q;
  assign goodCnt  = good_cnt_q;
  assign dropCnt  = drop_cnt_q;

endmodule
